pwm_capture: RTL and testbench

//   Receive-side counterpart of the on-chip PWM generator: measures an incoming PWM waveform.

---
 rtl/pwm_capture_if.sv | 30 +++
 rtl/pwm_capture.sv | 151 +++++++++++++++
 tb/tb_pwm_capture.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: measurement results published by the PWM capture block.
//   master : driven by pwm_capture
//   slave  : consumer of the measurements
// Signals:
//   high_cnt    CNT_W  high cycles of the last complete period
//   period_cnt  CNT_W  cycles between the last two rising edges
//   duty_code   4      recovered generator duty code
//   code_ok     1      duty_code reflects a nominal-period (or stuck-high) input
//   meas_valid  1      one-cycle pulse when the measurement fields update
//   stuck       1      no rising edge seen for TIMEOUT cycles
//   stuck_level 1      synchronised line level captured when stuck asserted
interface pwm_capture_if #(
   parameter int CNT_W = 8
);
   logic [CNT_W-1:0] high_cnt;
   logic [CNT_W-1:0] period_cnt;
   logic [3:0]       duty_code;
   logic             code_ok;
   logic             meas_valid;
   logic             stuck;
   logic             stuck_level;

   modport master (
      output high_cnt, period_cnt, duty_code, code_ok, meas_valid, stuck, stuck_level
   );

   modport slave (
      input  high_cnt, period_cnt, duty_code, code_ok, meas_valid, stuck, stuck_level
   );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM waveform.
//   Synchronises pwm_in, counts high and period cycles between successive rising
//   edges and publishes them with a one-cycle meas_valid pulse. Recovers the
//   generator's 4-bit duty code (high = duty+1 cycles of a NOM_PERIOD period) and
//   flags a line that stops toggling.
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   pwm_in  in   PWM input, asynchronous to clk
//   mif     master modport of pwm_capture_if (measurement outputs)
module pwm_capture #(
   parameter int CNT_W      = 8,
   parameter int TIMEOUT    = 64,
   parameter int NOM_PERIOD = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 pwm_in,
   pwm_capture_if.master        mif
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] TO_V    = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] NOM_V   = CNT_W'(NOM_PERIOD);
   localparam logic [CNT_W-1:0] HI_MAX  = CNT_W'(16);

   typedef enum logic [1:0] {IDLE, HIGH, LOW, STUCK} state_t;

   state_t           state, state_nx;
   logic             sync1, pwm_s, pwm_d;
   logic             rise, fall, timeout;
   logic             publish, go_stuck, clr_stuck;
   logic             code_ok_nx;
   logic [3:0]       duty_nx;
   logic [CNT_W-1:0] period_run, high_run;

   // Input synchroniser plus one delay stage for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         pwm_s <= 1'b0;
         pwm_d <= 1'b0;
      end else begin
         sync1 <= pwm_in;
         pwm_s <= sync1;
         pwm_d <= pwm_s;
      end
   end

   assign rise    = pwm_s & ~pwm_d;
   assign fall    = ~pwm_s & pwm_d;
   // A rise in the same cycle as the timeout takes priority
   assign timeout = (period_run == TO_V) && !rise;

   // Run counters: restart at 1 on a rise, saturate instead of wrapping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_run <= '0;
         high_run   <= '0;
      end else if (rise) begin
         period_run <= CNT_W'(1);
         high_run   <= CNT_W'(1);
      end else begin
         if (period_run != CNT_MAX)
            period_run <= period_run + CNT_W'(1);
         if (pwm_s && high_run != CNT_MAX)
            high_run <= high_run + CNT_W'(1);
      end
   end

   // Decode uses the pre-load counter values seen in the rise cycle.
   // high_run of 16 maps to code 15 through the 4-bit wrap of 0-1.
   assign code_ok_nx = (period_run == NOM_V) && (high_run != '0) && (high_run <= HI_MAX);
   assign duty_nx    = high_run[3:0] - 4'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      publish   = 1'b0;
      go_stuck  = 1'b0;
      clr_stuck = 1'b0;
      case (state)
         IDLE: begin
            if (rise)         state_nx = HIGH;
            else if (timeout) go_stuck = 1'b1;
         end
         HIGH: begin
            if (fall)         state_nx = LOW;
            else if (timeout) go_stuck = 1'b1;
         end
         LOW: begin
            if (rise) begin
               state_nx = HIGH;
               publish  = 1'b1;
            end else if (timeout) begin
               go_stuck = 1'b1;
            end
         end
         STUCK: begin
            // Leaving STUCK never publishes: the interval before it is not a real period
            if (rise) begin
               state_nx  = HIGH;
               clr_stuck = 1'b1;
            end else if (fall) begin
               state_nx  = IDLE;
               clr_stuck = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
      if (go_stuck) state_nx = STUCK;
   end

   // Result registers: hold between publishes; timeout only touches stuck/duty fields
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mif.high_cnt    <= '0;
         mif.period_cnt  <= '0;
         mif.duty_code   <= '0;
         mif.code_ok     <= 1'b0;
         mif.meas_valid  <= 1'b0;
         mif.stuck       <= 1'b0;
         mif.stuck_level <= 1'b0;
      end else begin
         mif.meas_valid <= publish;
         if (publish) begin
            mif.high_cnt   <= high_run;
            mif.period_cnt <= period_run;
            mif.code_ok    <= code_ok_nx;
            if (code_ok_nx) mif.duty_code <= duty_nx;
         end
         if (go_stuck) begin
            mif.stuck       <= 1'b1;
            mif.stuck_level <= pwm_s;
            // Stuck-high reads as full duty; stuck-low has no valid code
            if (pwm_s) begin
               mif.duty_code <= 4'hF;
               mif.code_ok   <= 1'b1;
            end else begin
               mif.code_ok   <= 1'b0;
            end
         end
         if (clr_stuck) mif.stuck <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;
   localparam int CNT_W   = 8;
   localparam int TIMEOUT = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic pwm_in = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   // pulse monitor state filled in by cyc()
   int   nvalid = 0;
   int   ndbl = 0;
   logic prev_mv = 1'b0;
   logic [CNT_W-1:0] lh, lp;
   logic [3:0] lc;
   logic lo;

   pwm_capture_if #(.CNT_W(CNT_W)) mif ();

   pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .NOM_PERIOD(16)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .pwm_in (pwm_in),
      .mif    (mif)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // drive pwm_in for one clock, sample 1ns after the edge
   task automatic cyc(input logic v);
      pwm_in = v;
      @(posedge clk);
      #1;
      if (mif.meas_valid === 1'b1) begin
         nvalid++;
         if (prev_mv) ndbl++;
         lh = mif.high_cnt;
         lp = mif.period_cnt;
         lc = mif.duty_code;
         lo = mif.code_ok;
      end
      prev_mv = mif.meas_valid;
   endtask

   task automatic pwm_period(input int hi, input int per);
      for (int i = 0; i < per; i++) cyc(i < hi);
   endtask

   task automatic clr_mon();
      nvalid = 0;
      ndbl = 0;
   endtask

   task automatic do_reset();
      pwm_in = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      prev_mv = 1'b0;
   endtask

   task automatic test_reset();
      pwm_in = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (mif.high_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_high_cnt: got %0d want 0", mif.high_cnt); end
      n_cmp++; if (mif.period_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_period_cnt: got %0d want 0", mif.period_cnt); end
      n_cmp++; if ({mif.duty_code, mif.code_ok, mif.meas_valid} !== 6'd0) begin n_bad++; $display("FAIL reset_duty_flags: got %b want 000000", {mif.duty_code, mif.code_ok, mif.meas_valid}); end
      n_cmp++; if ({mif.stuck, mif.stuck_level} !== 2'b00) begin n_bad++; $display("FAIL reset_stuck: got %b want 00", {mif.stuck, mif.stuck_level}); end
      rst_n = 1'b1;
      prev_mv = 1'b0;
      repeat (4) cyc(1'b0);
   endtask

   task automatic test_duty5();
      clr_mon();
      pwm_period(6, 16);
      n_cmp++; if (nvalid !== 0) begin n_bad++; $display("FAIL duty5_first_rise: got %0d pulses want 0", nvalid); end
      repeat (3) pwm_period(6, 16);
      n_cmp++; if (nvalid !== 3) begin n_bad++; $display("FAIL duty5_count: got %0d want 3", nvalid); end
      n_cmp++; if (lh !== 8'd6) begin n_bad++; $display("FAIL duty5_high: got %0d want 6", lh); end
      n_cmp++; if (lp !== 8'd16) begin n_bad++; $display("FAIL duty5_period: got %0d want 16", lp); end
      n_cmp++; if (lc !== 4'd5) begin n_bad++; $display("FAIL duty5_code: got %0d want 5", lc); end
      n_cmp++; if (lo !== 1'b1) begin n_bad++; $display("FAIL duty5_ok: got %0d want 1", lo); end
      n_cmp++; if (ndbl !== 0) begin n_bad++; $display("FAIL duty5_pulse_width: got %0d long pulses want 0", ndbl); end
   endtask

   task automatic test_duty0();
      clr_mon();
      repeat (3) pwm_period(1, 16);
      n_cmp++; if (nvalid !== 3) begin n_bad++; $display("FAIL duty0_count: got %0d want 3", nvalid); end
      n_cmp++; if (lh !== 8'd1) begin n_bad++; $display("FAIL duty0_high: got %0d want 1", lh); end
      n_cmp++; if (lp !== 8'd16) begin n_bad++; $display("FAIL duty0_period: got %0d want 16", lp); end
      n_cmp++; if ({lc, lo} !== 5'b0000_1) begin n_bad++; $display("FAIL duty0_code_ok: got %0d/%0d want 0/1", lc, lo); end
      n_cmp++; if (ndbl !== 0) begin n_bad++; $display("FAIL duty0_pulse_width: got %0d long pulses want 0", ndbl); end
   endtask

   task automatic test_period20();
      clr_mon();
      repeat (3) pwm_period(7, 20);
      n_cmp++; if (nvalid !== 3) begin n_bad++; $display("FAIL p20_count: got %0d want 3", nvalid); end
      n_cmp++; if (lh !== 8'd7) begin n_bad++; $display("FAIL p20_high: got %0d want 7", lh); end
      n_cmp++; if (lp !== 8'd20) begin n_bad++; $display("FAIL p20_period: got %0d want 20", lp); end
      n_cmp++; if (lo !== 1'b0) begin n_bad++; $display("FAIL p20_ok: got %0d want 0", lo); end
      n_cmp++; if (lc !== 4'd0) begin n_bad++; $display("FAIL p20_code_hold: got %0d want 0", lc); end
   endtask

   task automatic test_stuck_high();
      do_reset();
      repeat (4) cyc(1'b0);
      clr_mon();
      repeat (100) cyc(1'b1);
      n_cmp++; if (mif.stuck !== 1'b1) begin n_bad++; $display("FAIL sh_stuck: got %0d want 1", mif.stuck); end
      n_cmp++; if (mif.stuck_level !== 1'b1) begin n_bad++; $display("FAIL sh_level: got %0d want 1", mif.stuck_level); end
      n_cmp++; if (mif.duty_code !== 4'd15) begin n_bad++; $display("FAIL sh_code: got %0d want 15", mif.duty_code); end
      n_cmp++; if (mif.code_ok !== 1'b1) begin n_bad++; $display("FAIL sh_ok: got %0d want 1", mif.code_ok); end
      n_cmp++; if (nvalid !== 0) begin n_bad++; $display("FAIL sh_no_valid: got %0d want 0", nvalid); end
      n_cmp++; if ({mif.high_cnt, mif.period_cnt} !== 16'd0) begin n_bad++; $display("FAIL sh_cnt_hold: got %0d/%0d want 0/0", mif.high_cnt, mif.period_cnt); end
      repeat (5) cyc(1'b0);
      n_cmp++; if (mif.stuck !== 1'b0) begin n_bad++; $display("FAIL sh_release: got %0d want 0", mif.stuck); end
      clr_mon();
      repeat (2) pwm_period(4, 16);
      n_cmp++; if (nvalid !== 1) begin n_bad++; $display("FAIL sh_resume_count: got %0d want 1", nvalid); end
      n_cmp++; if ({lh, lp, lc, lo} !== {8'd4, 8'd16, 4'd3, 1'b1}) begin n_bad++; $display("FAIL sh_resume_meas: got %0d/%0d/%0d/%0d want 4/16/3/1", lh, lp, lc, lo); end
   endtask

   task automatic test_stuck_low();
      int n;
      do_reset();
      clr_mon();
      n = 0;
      while (n < 200 && mif.stuck !== 1'b1) begin
         cyc(1'b0);
         n++;
      end
      n_cmp++; if (n !== TIMEOUT + 1) begin n_bad++; $display("FAIL sl_latency: got %0d edges want %0d", n, TIMEOUT + 1); end
      n_cmp++; if (mif.stuck_level !== 1'b0) begin n_bad++; $display("FAIL sl_level: got %0d want 0", mif.stuck_level); end
      n_cmp++; if (mif.code_ok !== 1'b0) begin n_bad++; $display("FAIL sl_ok: got %0d want 0", mif.code_ok); end
      n_cmp++; if ({mif.high_cnt, mif.period_cnt, mif.duty_code} !== 20'd0) begin n_bad++; $display("FAIL sl_outputs: got %0d/%0d/%0d want 0/0/0", mif.high_cnt, mif.period_cnt, mif.duty_code); end
      n_cmp++; if (nvalid !== 0) begin n_bad++; $display("FAIL sl_no_valid: got %0d want 0", nvalid); end
   endtask

   task automatic test_reset_mid();
      repeat (3) pwm_period(6, 16);
      n_cmp++; if (mif.high_cnt !== 8'd6) begin n_bad++; $display("FAIL rm_pre_high: got %0d want 6", mif.high_cnt); end
      repeat (3) cyc(1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({mif.high_cnt, mif.period_cnt, mif.duty_code, mif.code_ok, mif.meas_valid, mif.stuck, mif.stuck_level} !== 24'd0) begin
         n_bad++; $display("FAIL rm_async_clear: got %0d/%0d/%0d/%0d want all 0", mif.high_cnt, mif.period_cnt, mif.duty_code, mif.code_ok);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      prev_mv = 1'b0;
      clr_mon();
      repeat (6) cyc(1'b1);
      repeat (10) cyc(1'b0);
      n_cmp++; if (nvalid !== 0) begin n_bad++; $display("FAIL rm_no_valid_first: got %0d want 0", nvalid); end
      cyc(1'b1);
      n_cmp++; if (mif.meas_valid !== 1'b0) begin n_bad++; $display("FAIL lat_k: got %0d want 0", mif.meas_valid); end
      cyc(1'b1);
      n_cmp++; if (mif.meas_valid !== 1'b0) begin n_bad++; $display("FAIL lat_k1: got %0d want 0", mif.meas_valid); end
      cyc(1'b1);
      n_cmp++; if (mif.meas_valid !== 1'b1) begin n_bad++; $display("FAIL lat_k2: got %0d want 1", mif.meas_valid); end
      n_cmp++; if ({mif.high_cnt, mif.period_cnt, mif.duty_code, mif.code_ok} !== {8'd6, 8'd16, 4'd5, 1'b1}) begin
         n_bad++; $display("FAIL rm_meas: got %0d/%0d/%0d/%0d want 6/16/5/1", mif.high_cnt, mif.period_cnt, mif.duty_code, mif.code_ok);
      end
      cyc(1'b1);
      n_cmp++; if (mif.meas_valid !== 1'b0) begin n_bad++; $display("FAIL lat_k3: got %0d want 0", mif.meas_valid); end
   endtask

   initial begin
      test_reset();
      test_duty5();
      test_duty0();
      test_period20();
      test_stuck_high();
      test_stuck_low();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
